// File: rtl/fall_alarm_controller.sv
// Debounces the fall detector flag, latches an alarm until acknowledged, escalates on timeout,
// enforces a post-acknowledge cooldown and keeps a saturating count of confirmed falls.
module fall_alarm_controller #(
  parameter int unsigned CONFIRM_CYCLES  = 4,
  parameter int unsigned ESCALATE_CYCLES = 16,
  parameter int unsigned COOLDOWN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fallDetected,
  input  logic       ack,
  input  logic       clrCount,
  output logic       alarm,
  output logic       escalate,
  output logic [7:0] fallCount,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StConfirm  = 2'd1,
    StAlarm    = 2'd2,
    StCooldown = 2'd3
  } stateT;

  // Terminal values of the shared run counter for each timed state.
  localparam logic [7:0] ConfirmLast  = 8'(CONFIRM_CYCLES - 1);
  localparam logic [7:0] EscalateLast = 8'(ESCALATE_CYCLES - 1);
  localparam logic [7:0] CooldownLast = 8'(COOLDOWN_CYCLES - 1);

  stateT      stateQ, stateD;
  logic [7:0] cntQ, cntD;
  logic       alarmQ, alarmD;
  logic       escalateQ, escalateD;
  logic [7:0] fallCountQ, fallCountD;
  logic       confirmed;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      cntQ       <= 8'd0;
      alarmQ     <= 1'b0;
      escalateQ  <= 1'b0;
      fallCountQ <= 8'd0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      alarmQ     <= alarmD;
      escalateQ  <= escalateD;
      fallCountQ <= fallCountD;
    end
  end

  // Next-state and run-counter logic; the counter restarts on every state change.
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    confirmed = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (fallDetected) begin
          stateD = StConfirm;
          cntD   = 8'd1;
        end
      end
      StConfirm: begin
        if (!fallDetected) begin
          stateD = StIdle;
          cntD   = 8'd0;
        end else if (cntQ == ConfirmLast) begin
          stateD    = StAlarm;
          cntD      = 8'd0;
          confirmed = 1'b1;
        end else begin
          cntD = cntQ + 8'd1;
        end
      end
      StAlarm: begin
        if (ack) begin
          stateD = StCooldown;
          cntD   = 8'd0;
        end else if (cntQ != EscalateLast) begin
          cntD = cntQ + 8'd1;
        end
      end
      StCooldown: begin
        if (cntQ == CooldownLast) begin
          stateD = StIdle;
          cntD   = 8'd0;
        end else begin
          cntD = cntQ + 8'd1;
        end
      end
      default: begin
        stateD = StIdle;
        cntD   = 8'd0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    alarmD     = (stateD == StAlarm);
    escalateD  = 1'b0;
    fallCountD = fallCountQ;
    // Acknowledge wins over a timeout landing on the same edge.
    if ((stateQ == StAlarm) && !ack) begin
      escalateD = escalateQ | (cntQ == EscalateLast);
    end
    if (clrCount) begin
      fallCountD = 8'd0;
    end else if (confirmed && (fallCountQ != 8'hFF)) begin
      fallCountD = fallCountQ + 8'd1;
    end
  end

  assign alarm     = alarmQ;
  assign escalate  = escalateQ;
  assign fallCount = fallCountQ;
  assign state     = stateQ;

endmodule

// File: tb/tb_fall_alarm_controller.sv
// Scoreboarded random/directed bench for fall_alarm_controller against a behavioural model.
module tb_fall_alarm_controller;

  localparam int unsigned ConfirmN  = 4;
  localparam int unsigned EscalateN = 16;
  localparam int unsigned CooldownN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fallDetected = 1'b0;
  logic       ack = 1'b0;
  logic       clrCount = 1'b0;
  logic       alarm;
  logic       escalate;
  logic [7:0] fallCount;
  logic [1:0] state;

  fall_alarm_controller #(
    .CONFIRM_CYCLES (ConfirmN),
    .ESCALATE_CYCLES(EscalateN),
    .COOLDOWN_CYCLES(CooldownN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fallDetected(fallDetected),
    .ack         (ack),
    .clrCount    (clrCount),
    .alarm       (alarm),
    .escalate    (escalate),
    .fallCount   (fallCount),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       al;
    logic       es;
    logic [7:0] cnt;
  } expT;

  expT expQ[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Behavioural model: mode follows the externally visible state numbering.
  int mMode = 0;       // 0 idle, 1 confirming, 2 alarm, 3 cooldown
  int mHighs = 0;      // consecutive highs seen while confirming
  int mAlarmAge = 0;   // edges spent in alarm without acknowledge
  int mCoolLeft = 0;   // cooldown edges still to serve
  bit mEsc = 1'b0;
  int mFalls = 0;
  int mConfirms = 0;   // total confirmations ever, never reset

  function automatic void modelStep(input bit r, input bit f, input bit a, input bit c);
    bit conf = 1'b0;
    if (r) begin
      mMode = 0; mHighs = 0; mAlarmAge = 0; mCoolLeft = 0; mEsc = 1'b0; mFalls = 0;
      return;
    end
    case (mMode)
      0: if (f) begin mMode = 1; mHighs = 1; end
      1: begin
        if (!f) begin
          mMode = 0; mHighs = 0;
        end else begin
          mHighs++;
          if (mHighs >= ConfirmN) begin
            mMode = 2; mAlarmAge = 0; conf = 1'b1; mConfirms++;
          end
        end
      end
      2: begin
        if (a) begin
          mMode = 3; mCoolLeft = CooldownN; mEsc = 1'b0;
        end else begin
          mAlarmAge++;
          if (mAlarmAge >= EscalateN) mEsc = 1'b1;
        end
      end
      default: begin
        mCoolLeft--;
        if (mCoolLeft == 0) mMode = 0;
      end
    endcase
    if (c) mFalls = 0;
    else if (conf) mFalls = (mFalls >= 255) ? 255 : mFalls + 1;
  endfunction

  task automatic step(input bit r, input bit f, input bit a, input bit c);
    expT e;
    @(negedge clk);
    rst = r; fallDetected = f; ack = a; clrCount = c;
    modelStep(r, f, a, c);
    e.st  = 2'(mMode);
    e.al  = (mMode == 2);
    e.es  = mEsc;
    e.cnt = 8'(mFalls);
    expQ.push_back(e);
  endtask

  // Monitor: every edge the DUT presents a new output vector.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        vectors++;
        if ({state, alarm, escalate, fallCount} !== e) begin
          miscompares++;
          $display("FAIL vec%0d: got state=%0d alarm=%0b escalate=%0b fallCount=%0d, want state=%0d alarm=%0b escalate=%0b fallCount=%0d",
                   vectors, state, alarm, escalate, fallCount, e.st, e.al, e.es, e.cnt);
        end
      end
    end
  end

  task automatic goAlarm();
    for (int i = 0; i < 20 && mMode != 2; i++) step(0, 1, 0, 0);
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int startConf;
    bit c;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Debounce reject, then high-low-high restart.
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    settle();
    // Confirm, ack 5 cycles after alarm, flag held through cooldown.
    goAlarm();
    repeat (4) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    repeat (12) step(0, 1, 0, 0);
    settle();
    // Escalation then ack.
    goAlarm();
    repeat (20) step(0, 1'($urandom_range(1)), 0, 0);
    step(0, 0, 1, 0);
    settle();
    // Ack on the 16th alarm edge.
    goAlarm();
    repeat (15) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    settle();
    // Saturation, then clear colliding with a confirmation.
    startConf = mConfirms;
    for (int i = 0; i < 5000 && mConfirms < startConf + 256; i++) step(0, 1, 1, 0);
    for (int i = 0; i < 40; i++) begin
      c = (mMode == 1) && (mHighs == ConfirmN - 1);
      step(0, 1, 1, c);
      if (c) break;
    end
    step(0, 0, 1, 0);
    settle();
    // Reset in confirm, in escalated alarm, in cooldown.
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    goAlarm();
    repeat (17) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    goAlarm();
    step(0, 1, 1, 0);
    repeat (3) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    settle();
    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199) == 0, $urandom_range(99) < 70, $urandom_range(99) < 8,
           $urandom_range(99) < 2);
    repeat (3) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fall_alarm_controller.md
# fall_alarm_controller

Downstream consumer of the fall detector's `fallDetected` flag. It debounces the flag over a confirmation window and raises a latched `alarm` until an operator acknowledges it. If no acknowledge arrives in time it asserts `escalate`. After an acknowledge it enforces a cooldown before re-arming, and it keeps a saturating count of confirmed falls for the status display.

## Interface
- `CONFIRM_CYCLES`, default 4: consecutive sampled-high cycles of `fallDetected` needed to confirm a fall; legal range 2..255.
- `ESCALATE_CYCLES`, default 16: cycles in ALARM without `ack` before `escalate` asserts; legal range 1..255.
- `COOLDOWN_CYCLES`, default 8: cycles spent in COOLDOWN after `ack`; legal range 1..255.
- `clk` input 1: single clock; all logic updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fallDetected` input 1: level flag from the fall detector, sampled every edge.
- `ack` input 1: operator acknowledge, sampled every edge; ignored outside ALARM.
- `clrCount` input 1: synchronous clear of `fallCount`.
- `alarm` output 1: registered; high exactly while in ALARM.
- `escalate` output 1: registered; sticky while in ALARM once the escalation timeout expires.
- `fallCount` output 8: registered count of confirmed falls; saturates at 255.
- `state` output 2: current state. IDLE=0, CONFIRM=1, ALARM=2, COOLDOWN=3.

## Operation
- Internal logic: one 8-bit run counter `cnt`, shared by CONFIRM, ALARM and COOLDOWN, and cleared on every state change. One 2-bit state register.
- **IDLE**
  - `fallDetected`=1 → CONFIRM with `cnt`=1.
  - Otherwise stay in IDLE.
- **CONFIRM**
  - `fallDetected`=0 → IDLE. No count change.
  - `fallDetected`=1 and `cnt`==CONFIRM_CYCLES-1 → ALARM, and `fallCount` increments (saturating).
  - Otherwise `cnt`++.
- **ALARM**
  - `alarm`=1 throughout.
  - `ack`=1 → COOLDOWN; `escalate` clears and `alarm` clears on the same edge.
  - Otherwise, if `cnt`==ESCALATE_CYCLES-1 → `escalate`=1 and it stays set; `cnt` holds.
  - Otherwise `cnt`++.
  - `ack` has priority over escalation on the same edge.
  - `fallDetected` is ignored in ALARM.
- **COOLDOWN**
  - `fallDetected` and `ack` are ignored.
  - `cnt`==COOLDOWN_CYCLES-1 → IDLE.
  - Otherwise `cnt`++.
  - If `fallDetected` is still high when IDLE is re-entered, a new confirmation starts on the next edge.
- **`fallCount` arithmetic**
  - 8-bit unsigned; an increment at 255 holds at 255 (no wrap).
  - `clrCount`=1 sets it to 0. If a clear and an increment land on the same edge, the clear wins (result 0).
  - `clrCount` does not affect state, `alarm` or `escalate`.

## Timing
- Reset values: `alarm`=0, `escalate`=0, `fallCount`=0, `state`=IDLE(0), `cnt`=0.
- Reset asserted mid-operation in any state returns to these values on the next edge, discarding progress. Reset overrides every other input.
- Alarm latency: with `fallDetected` high at edges E1..E(CONFIRM_CYCLES), `alarm` goes high after edge E(CONFIRM_CYCLES). With defaults that is 4 edges.
- A single low sample inside the window restarts confirmation. A high-low-high pattern needs a full new run of CONFIRM_CYCLES highs.
- Escalation latency: `escalate` goes high after the ESCALATE_CYCLES-th edge spent in ALARM with `ack`=0, counting from the first edge after entry. With defaults that is 16 edges.
- `ack` seen on an edge in ALARM → `alarm`=0 and `state`=COOLDOWN after that edge.
- Total COOLDOWN duration is exactly COOLDOWN_CYCLES cycles; the earliest possible re-confirmation edge comes after that.
- The block has no combinational path from any input to any output.

## Test plan
- **Debounce reject:** `fallDetected` high 3 cycles then low (defaults) → `state` goes 1 then back to 0; `alarm`=0; `fallCount`=0.
- **Confirm and ack:** `fallDetected` held high; `ack` pulsed 5 cycles after `alarm` rises → `alarm` rises after the 4th high edge; `fallCount`=1; `state`=3 for 8 cycles, then 0, then 1 (re-confirming the still-high flag).
- **Escalation:** confirm a fall, hold `ack`=0 → `escalate` rises after 16 edges in ALARM. Then `ack`=1 → `escalate`=0 and `alarm`=0 after that edge.
- **Ack/escalate collision:** `ack`=1 on the 16th ALARM edge → `escalate` never asserts; `state`=3.
- **Counter saturate and clear:** force 256 confirmed falls → `fallCount`=255. Then `clrCount` on the same edge as a confirmation → `fallCount`=0.
- **Reset mid-operation:** `rst` asserted in CONFIRM, in ALARM with `escalate`=1, and in COOLDOWN → all outputs 0 and `state`=0 after one edge.
